// File: rtl/fifo_sync.sv
// fifo_sync: single-clock show-ahead FIFO, 2**ASIZE words of DSIZE bits.
// The head word is driven combinationally on rdata. The wfull and rempty
// flags are registered and updated on the same edge as the pointers.
// Optional feature macro: FIFO_COUNT_EN adds a registered occupancy port, count.
module fifo_sync #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
`ifdef FIFO_COUNT_EN
  ,
  output logic [ASIZE:0]   count
`endif
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_nxt, rptr_nxt;
  logic             wr_en, rd_en;
  logic             wfull_nxt, rempty_nxt;

  // Accepted transfers. Gating with rst_n keeps stray requests during reset
  // from touching memory.
  always_comb begin
    wr_en = winc && !wfull && rst_n;
    rd_en = rinc && !rempty && rst_n;
  end

  // Next-state pointers and flags. The pointer MSB is the wrap bit.
  always_comb begin
    wptr_nxt   = wptr + {{ASIZE{1'b0}}, wr_en};
    rptr_nxt   = rptr + {{ASIZE{1'b0}}, rd_en};
    rempty_nxt = (wptr_nxt == rptr_nxt);
    wfull_nxt  = (wptr_nxt == {~rptr_nxt[ASIZE], rptr_nxt[ASIZE-1:0]});
  end

  // Pointer and flag registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
      wfull  <= 1'b0;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      rempty <= rempty_nxt;
      wfull  <= wfull_nxt;
    end
  end

`ifdef FIFO_COUNT_EN
  // Occupancy register, kept in step with the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= wptr_nxt - rptr_nxt;
  end
`endif

  // Storage array. Its contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  // Show-ahead read port.
  always_comb begin
    rdata = mem[rptr[ASIZE-1:0]];
  end

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed and random stimulus against a queue model of fifo_sync.
module tb_fifo_sync;
  localparam int DSIZE = 8;
  localparam int ASIZE = 3;
  localparam int DEPTH = 1 << ASIZE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic [DSIZE-1:0] wdata = '0;
  logic [DSIZE-1:0] rdata;
  logic             wfull, rempty;
`ifdef FIFO_COUNT_EN
  logic [ASIZE:0]   count;
`endif

  int total = 0;
  int bad   = 0;
  logic [DSIZE-1:0] q[$];
  logic [DSIZE-1:0] hold;

  fifo_sync #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
`ifdef FIFO_COUNT_EN
    ,
    .count  (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Status as the model sees it.
  task automatic chk_state(input string tag);
    chk({tag, ".rempty"}, 32'(rempty), 32'(q.size() == 0));
    chk({tag, ".wfull"},  32'(wfull),  32'(q.size() == DEPTH));
    if (q.size() != 0) chk({tag, ".head"}, 32'(rdata), 32'(q[0]));
`ifdef FIFO_COUNT_EN
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
`endif
  endtask

  // One clock cycle. It is entered and left at posedge+1.
  task automatic cyc(input string tag, input bit w, input bit r, input logic [DSIZE-1:0] d);
    bit do_w, do_r;
    winc = w; rinc = r; wdata = d;
    @(negedge clk);
    do_w = w && (q.size() < DEPTH);
    do_r = r && (q.size() > 0);
    if (do_r) chk({tag, ".pop"}, 32'(rdata), 32'(q[0]));
    @(posedge clk);
    if (do_r) void'(q.pop_front());
    if (do_w) q.push_back(d);
    #1;
    winc = 1'b0; rinc = 1'b0;
    chk_state(tag);
  endtask

  initial begin
    // 1: reset held for 3 cycles with unknown requests, then rinc pulses on empty.
    winc = 1'bx; rinc = 1'bx;
    repeat (3) @(posedge clk);
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("reset");
    for (int i = 0; i < 3; i++) cyc("rd_empty", 1'b0, 1'b1, '0);

    // 2: write 6 bytes, then read 6.
    for (int i = 0; i < 6; i++) cyc("w6", 1'b1, 1'b0, DSIZE'($urandom));
    for (int i = 0; i < 6; i++) cyc("r6", 1'b0, 1'b1, '0);

    // 3: fill the FIFO, then attempt 3 writes of 8'hAA, which must be dropped.
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 1'b0, DSIZE'($urandom));
    chk("full_after_fill", 32'(wfull), 32'd1);
    for (int i = 0; i < 3; i++) cyc("w_full", 1'b1, 1'b0, 8'hAA);

    // 4: drain 8, then 3 extra reads that must leave rdata unchanged.
    for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 1'b1, '0);
    chk("empty_after_drain", 32'(rempty), 32'd1);
    hold = rdata;
    for (int i = 0; i < 3; i++) cyc("r_extra", 1'b0, 1'b1, '0);
    chk("rdata_stable", 32'(rdata), 32'(hold));

    // 5: simultaneous write and read at level 4, at full, and at empty.
    for (int i = 0; i < 4; i++) cyc("lvl4", 1'b1, 1'b0, DSIZE'($urandom));
    cyc("both_mid", 1'b1, 1'b1, DSIZE'($urandom));
    chk("both_mid_level", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) cyc("lvl8", 1'b1, 1'b0, DSIZE'($urandom));
    cyc("both_full", 1'b1, 1'b1, 8'h5A);
    chk("both_full_wfull", 32'(wfull), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cyc("to_empty", 1'b0, 1'b1, '0);
    cyc("both_empty", 1'b1, 1'b1, 8'hC3);
    chk("both_empty_rempty", 32'(rempty), 32'd0);
    cyc("pop_c3", 1'b0, 1'b1, '0);

    // 6: 20 interleaved single writes and reads through pointer wrap.
    for (int i = 0; i < 20; i++) begin
      cyc("wrap_w", 1'b1, 1'b0, DSIZE'($urandom));
      cyc("wrap_r", 1'b0, 1'b1, '0);
    end

    // Random mix of requests.
    for (int i = 0; i < 300; i++)
      cyc("rand", 1'($urandom), 1'($urandom), DSIZE'($urandom));

    // Reset pulse at level 5, which must clear the FIFO immediately.
    while (q.size() > 5) cyc("to5", 1'b0, 1'b1, '0);
    while (q.size() < 5) cyc("to5", 1'b1, 1'b0, DSIZE'($urandom));
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("async_rst_rempty", 32'(rempty), 32'd1);
    chk("async_rst_wfull",  32'(wfull),  32'd0);
`ifdef FIFO_COUNT_EN
    chk("async_rst_count",  32'(count),  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("post_rst");
    cyc("post_rst_w", 1'b1, 1'b0, 8'h3C);
    cyc("post_rst_r", 1'b0, 1'b1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
